// File: rtl/rv32i_program_loader.sv
// Boot-time program loader: takes a framed little-endian byte stream (4-byte word count,
// then the words) and writes it to instruction memory, holding the core in reset until done.
module rv32i_program_loader #(
    parameter logic [31:0] BASE_ADDR = 32'd0,
    parameter int unsigned MAX_WORDS = 1024
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_load_start,
    input  logic        i_byte_valid,
    input  logic [7:0]  i_byte_data,
    output logic        o_byte_ready,
    output logic        o_instruction_wr_en,
    output logic [31:0] o_instruction_wr_addr,
    output logic [31:0] o_instruction_wr_data,
    input  logic        i_instruction_wr_valid,
    output logic        o_core_rst,
    output logic        o_busy,
    output logic        o_load_done,
    output logic        o_load_error
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_HDR,
        S_DATA,
        S_WRITE,
        S_DONE,
        S_ERROR
    } state_t;

    localparam logic [31:0] MAX_COUNT = 32'(MAX_WORDS);

    state_t      state_q, state_d;
    logic [1:0]  byte_idx_q, byte_idx_d;
    logic [31:0] asm_q, asm_d;
    logic [15:0] remaining_q, remaining_d;
    logic        wr_en_q, wr_en_d;
    logic [31:0] wr_addr_q, wr_addr_d;
    logic [31:0] wr_data_q, wr_data_d;
    logic        ready_q, ready_d;
    logic        core_rst_q, core_rst_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        error_q, error_d;

    logic        byte_fire;
    logic [31:0] asm_shift;

    // Bytes shift in from the top so the first byte of a group lands in bits 7:0.
    assign byte_fire = i_byte_valid && ready_q;
    assign asm_shift = {i_byte_data, asm_q[31:8]};

    always_comb begin
        state_d     = state_q;
        byte_idx_d  = byte_idx_q;
        asm_d       = asm_q;
        remaining_d = remaining_q;
        wr_en_d     = wr_en_q;
        wr_addr_d   = wr_addr_q;
        wr_data_d   = wr_data_q;
        ready_d     = ready_q;
        core_rst_d  = core_rst_q;
        busy_d      = busy_q;
        done_d      = done_q;
        error_d     = error_q;

        case (state_q)
            S_IDLE, S_DONE, S_ERROR: begin
                if (i_load_start) begin
                    state_d    = S_HDR;
                    byte_idx_d = 2'd0;
                    wr_addr_d  = BASE_ADDR;
                    ready_d    = 1'b1;
                    core_rst_d = 1'b1;
                    busy_d     = 1'b1;
                    done_d     = 1'b0;
                    error_d    = 1'b0;
                end
            end
            S_HDR: begin
                if (byte_fire) begin
                    asm_d      = asm_shift;
                    byte_idx_d = byte_idx_q + 2'd1;
                    if (byte_idx_q == 2'd3) begin
                        if (asm_shift == 32'd0) begin
                            state_d    = S_DONE;
                            ready_d    = 1'b0;
                            core_rst_d = 1'b0;
                            busy_d     = 1'b0;
                            done_d     = 1'b1;
                        end else if (asm_shift > MAX_COUNT) begin
                            state_d = S_ERROR;
                            ready_d = 1'b0;
                            busy_d  = 1'b0;
                            error_d = 1'b1;
                        end else begin
                            state_d     = S_DATA;
                            remaining_d = asm_shift[15:0];
                        end
                    end
                end
            end
            S_DATA: begin
                if (byte_fire) begin
                    asm_d      = asm_shift;
                    byte_idx_d = byte_idx_q + 2'd1;
                    if (byte_idx_q == 2'd3) begin
                        state_d   = S_WRITE;
                        wr_data_d = asm_shift;
                        wr_en_d   = 1'b1;
                        ready_d   = 1'b0;
                    end
                end
            end
            S_WRITE: begin
                // Request, address and data stay frozen until memory commits the word.
                if (i_instruction_wr_valid) begin
                    wr_en_d     = 1'b0;
                    wr_addr_d   = wr_addr_q + 32'd4;
                    remaining_d = remaining_q - 16'd1;
                    if (remaining_q == 16'd1) begin
                        state_d    = S_DONE;
                        core_rst_d = 1'b0;
                        busy_d     = 1'b0;
                        done_d     = 1'b1;
                    end else begin
                        state_d = S_DATA;
                        ready_d = 1'b1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q     <= S_IDLE;
            byte_idx_q  <= 2'd0;
            asm_q       <= 32'd0;
            remaining_q <= 16'd0;
            wr_en_q     <= 1'b0;
            wr_addr_q   <= BASE_ADDR;
            wr_data_q   <= 32'd0;
            ready_q     <= 1'b0;
            core_rst_q  <= 1'b1;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            byte_idx_q  <= byte_idx_d;
            asm_q       <= asm_d;
            remaining_q <= remaining_d;
            wr_en_q     <= wr_en_d;
            wr_addr_q   <= wr_addr_d;
            wr_data_q   <= wr_data_d;
            ready_q     <= ready_d;
            core_rst_q  <= core_rst_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            error_q     <= error_d;
        end
    end

    assign o_byte_ready          = ready_q;
    assign o_instruction_wr_en   = wr_en_q;
    assign o_instruction_wr_addr = wr_addr_q;
    assign o_instruction_wr_data = wr_data_q;
    assign o_core_rst            = core_rst_q;
    assign o_busy                = busy_q;
    assign o_load_done           = done_q;
    assign o_load_error          = error_q;

endmodule

// File: tb/tb_rv32i_program_loader.sv
// Randomised frame-level bench for rv32i_program_loader: a memory responder with programmable
// ack delay collects writes, and each frame is compared with the writes the framing rules imply.
module tb_rv32i_program_loader;

    localparam logic [31:0] BASE = 32'h100;
    localparam int          MAXW = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        load_start;
    logic        byte_valid;
    logic [7:0]  byte_data;
    logic        byte_ready;
    logic        wr_en;
    logic [31:0] wr_addr;
    logic [31:0] wr_data;
    logic        wr_valid;
    logic        core_rst;
    logic        busy;
    logic        load_done;
    logic        load_error;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    rv32i_program_loader #(.BASE_ADDR(BASE), .MAX_WORDS(MAXW)) dut (
        .i_clk                  (clk),
        .i_rst                  (rst),
        .i_load_start           (load_start),
        .i_byte_valid           (byte_valid),
        .i_byte_data            (byte_data),
        .o_byte_ready           (byte_ready),
        .o_instruction_wr_en    (wr_en),
        .o_instruction_wr_addr  (wr_addr),
        .o_instruction_wr_data  (wr_data),
        .i_instruction_wr_valid (wr_valid),
        .o_core_rst             (core_rst),
        .o_busy                 (busy),
        .o_load_done            (load_done),
        .o_load_error           (load_error)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Memory responder: acks each request after ack_delay extra cycles, logs committed writes.
    int          ack_delay = 1;
    bit          ack_noise = 1'b0;
    int          wait_cnt = 0;
    int          last_ack_cyc = -10;
    logic [31:0] hold_addr, hold_data;
    logic [63:0] got_q[$];

    initial begin
        wr_valid = 1'b0;
        forever begin
            @(negedge clk);
            wr_valid = 1'b0;
            if (wr_en === 1'b1 && rst === 1'b0) begin
                if (wait_cnt == 0) begin
                    hold_addr = wr_addr;
                    hold_data = wr_data;
                end else begin
                    checks++;
                    if (wr_addr !== hold_addr || wr_data !== hold_data) begin
                        errors++;
                        $display("FAIL write_stable addr %h data %h required addr %h data %h",
                                 wr_addr, wr_data, hold_addr, hold_data);
                    end
                end
                checks++;
                if (byte_ready !== 1'b0) begin
                    errors++;
                    $display("FAIL ready_during_write ready %b required 0", byte_ready);
                end
                if (wait_cnt >= ack_delay) begin
                    wr_valid = 1'b1;
                    got_q.push_back({wr_addr, wr_data});
                    last_ack_cyc = cyc;
                    wait_cnt = 0;
                end else begin
                    wait_cnt++;
                end
            end else begin
                wait_cnt = 0;
                wr_valid = ack_noise ? 1'($urandom_range(1)) : 1'b0;
            end
        end
    end

    task automatic start_load(input string name);
        @(negedge clk);
        load_start = 1'b1;
        @(negedge clk);
        load_start = 1'b0;
        checks++;
        if ({busy, core_rst, byte_ready, load_done, load_error} !== 5'b11100) begin
            errors++;
            $display("FAIL %s_start busy/core_rst/ready/done/error %b required 11100", name,
                     {busy, core_rst, byte_ready, load_done, load_error});
        end
    endtask

    task automatic send_bytes(input logic [7:0] bq[$], input int valid_pct, input int start_at);
        int  idx = 0;
        int  budget = 0;
        bit  pulsed = 1'b0;
        while (idx < bq.size() && budget < 3000) begin
            @(negedge clk);
            load_start = 1'b0;
            if (start_at >= 0 && idx == start_at && !pulsed) begin
                load_start = 1'b1;
                pulsed = 1'b1;
            end
            byte_valid = ($urandom_range(99) < valid_pct);
            byte_data  = byte_valid ? bq[idx] : 8'($urandom);
            if (byte_valid && byte_ready === 1'b1) idx++;
            budget++;
        end
        @(negedge clk);
        byte_valid = 1'b0;
        load_start = 1'b0;
        checks++;
        if (idx != bq.size()) begin
            errors++;
            $display("FAIL byte_budget sent %0d bytes required %0d", idx, bq.size());
        end
    endtask

    task automatic wait_idle(input string name, input bit timed);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (busy === 1'b1 && n < 500);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL %s_timeout busy %b required 0", name, busy);
        end else if (timed) begin
            checks++;
            if (cyc != last_ack_cyc + 1 || core_rst !== 1'b0) begin
                errors++;
                $display("FAIL %s_core_rst_latency release cycle %0d core_rst %b required cycle %0d core_rst 0",
                         name, cyc, core_rst, last_ack_cyc + 1);
            end
        end
    endtask

    // Reference: a header of N is accepted iff 1..MAXW; word k lands at BASE+4k.
    task automatic run_frame(input string name, input logic [31:0] count, input logic [31:0] words[$],
                             input int delay, input int valid_pct, input int start_at);
        logic [7:0]  bq[$];
        logic [63:0] exp_q[$];
        logic [31:0] w;
        logic [31:0] exp_addr;
        bit          accepted;
        bit          good;
        accepted = (count != 0) && (count <= MAXW);
        good     = (count <= MAXW);
        for (int i = 0; i < 4; i++) bq.push_back(count[8*i +: 8]);
        if (accepted) begin
            for (int k = 0; k < int'(count); k++) begin
                w = words[k];
                for (int i = 0; i < 4; i++) bq.push_back(w[8*i +: 8]);
                exp_q.push_back({BASE + 32'(4 * k), w});
            end
        end
        exp_addr = BASE + 32'(4 * exp_q.size());
        ack_delay = delay;
        got_q.delete();
        start_load(name);
        send_bytes(bq, valid_pct, start_at);
        wait_idle(name, accepted);
        checks++;
        if (got_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL %s_write_count got %0d required %0d", name, got_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            checks++;
            if (got_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL %s_write%0d got addr %h data %h required addr %h data %h", name, i,
                         got_q[i][63:32], got_q[i][31:0], exp_q[i][63:32], exp_q[i][31:0]);
            end
        end
        checks++;
        if ({load_done, load_error, core_rst, byte_ready, wr_en} !== {good, !good, !good, 2'b00} ||
            wr_addr !== exp_addr) begin
            errors++;
            $display("FAIL %s_status done/error/core_rst/ready/wr_en %b addr %h required %b addr %h",
                     name, {load_done, load_error, core_rst, byte_ready, wr_en}, wr_addr,
                     {good, !good, !good, 2'b00}, exp_addr);
        end
        $display("frame %s count %0d writes %0d done %b error %b", name, count, got_q.size(),
                 load_done, load_error);
    endtask

    task automatic rand_words(input int n, output logic [31:0] wq[$]);
        wq.delete();
        for (int i = 0; i < n; i++) wq.push_back($urandom);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ({wr_en, byte_ready, busy, load_done, load_error, core_rst} !== 6'b000001 ||
            wr_addr !== BASE || wr_data !== 32'd0) begin
            errors++;
            $display("FAIL reset_values flags %b addr %h data %h required 000001 addr %h data 0",
                     {wr_en, byte_ready, busy, load_done, load_error, core_rst}, wr_addr, wr_data, BASE);
        end
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            byte_valid = 1'($urandom_range(1));
            byte_data  = 8'($urandom);
        end
        @(negedge clk);
        byte_valid = 1'b0;
        checks++;
        if ({byte_ready, busy, core_rst, wr_addr} !== {3'b001, BASE}) begin
            errors++;
            $display("FAIL idle_after_reset ready/busy/core_rst %b addr %h required 001 addr %h",
                     {byte_ready, busy, core_rst}, wr_addr, BASE);
        end
        $display("reset checked");
    endtask

    task automatic test_basic();
        logic [31:0] wq[$];
        wq = '{32'h0000_0013, 32'h0010_0093};
        run_frame("basic", 32'd2, wq, 1, 100, -1);
    endtask

    task automatic test_boundaries();
        logic [31:0] wq[$];
        wq.delete();
        run_frame("zero_hdr", 32'd0, wq, 1, 100, -1);
        run_frame("too_long", 32'd5, wq, 1, 100, -1);
        run_frame("huge_hdr", 32'h0001_0001, wq, 1, 100, -1);
        rand_words(1, wq);
        run_frame("recover", 32'd1, wq, 0, 100, -1);
        rand_words(MAXW, wq);
        run_frame("max_len", 32'(MAXW), wq, 0, 100, -1);
    endtask

    task automatic test_slow_ack();
        logic [31:0] wq[$];
        rand_words(3, wq);
        run_frame("slow_ack", 32'd3, wq, 5, 100, -1);
    endtask

    task automatic test_random_valid_mid_start();
        logic [31:0] wq[$];
        rand_words(3, wq);
        run_frame("mid_start", 32'd3, wq, 2, 50, 6);
    endtask

    task automatic test_idle_valid();
        logic [31:0] addr_before;
        addr_before = wr_addr;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            byte_valid = 1'b1;
            byte_data  = 8'($urandom);
        end
        @(negedge clk);
        byte_valid = 1'b0;
        checks++;
        if ({byte_ready, busy, load_done, core_rst} !== 4'b0010 || wr_addr !== addr_before) begin
            errors++;
            $display("FAIL idle_valid ready/busy/done/core_rst %b addr %h required 0010 addr %h",
                     {byte_ready, busy, load_done, core_rst}, wr_addr, addr_before);
        end
        $display("idle valid checked");
    endtask

    task automatic test_back_to_back();
        logic [31:0] wq[$];
        int          n;
        ack_noise = 1'b1;
        for (int f = 0; f < 8; f++) begin
            n = $urandom_range(MAXW + 1);
            rand_words(n, wq);
            run_frame($sformatf("b2b%0d", f), 32'(n), wq, $urandom_range(3), 30 + $urandom_range(70), -1);
        end
        ack_noise = 1'b0;
    endtask

    task automatic test_async_reset();
        logic [7:0]  bq[$];
        logic [31:0] wq[$];
        int          n = 0;
        bq = '{8'h02, 8'h00, 8'h00, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
        ack_delay = 1000;
        got_q.delete();
        start_load("async_rst");
        send_bytes(bq, 100, -1);
        while (wr_en !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (wr_en !== 1'b1 || wr_data !== 32'hDEAD_BEEF) begin
            errors++;
            $display("FAIL async_rst_pending wr_en %b data %h required 1 data deadbeef", wr_en, wr_data);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({wr_en, byte_ready, busy, load_done, load_error, core_rst} !== 6'b000001 ||
            wr_addr !== BASE || wr_data !== 32'd0 || got_q.size() != 0) begin
            errors++;
            $display("FAIL async_rst_values flags %b addr %h data %h writes %0d required 000001 addr %h data 0 writes 0",
                     {wr_en, byte_ready, busy, load_done, load_error, core_rst}, wr_addr, wr_data,
                     got_q.size(), BASE);
        end
        @(negedge clk);
        rst = 1'b0;
        $display("async reset checked");
        rand_words(2, wq);
        run_frame("after_rst", 32'd2, wq, 0, 100, -1);
    endtask

    initial begin
        rst        = 1'b1;
        load_start = 1'b0;
        byte_valid = 1'b0;
        byte_data  = 8'd0;
        test_reset();
        test_basic();
        test_boundaries();
        test_slow_ack();
        test_random_valid_mid_start();
        test_idle_valid();
        test_back_to_back();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
